mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single synchronous `Ram` port between the `Fetch` stage (instruction reads) and the `Memory` stage (data loads and stores). A three-state controller runs the accesses. Data accesses win by default. An optional starvation guard forces a fetch grant after a bounded run of data grants. The block sits between the two pipeline stages and the RAM instance inside `cpu`.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, width of the word address on all ports
- `DATA_WIDTH`, 32, width of the data word
- `STARVE_LIMIT`, 4, maximum number of consecutive data grants while a fetch is pending (guard builds only), range 1..15

Ports:
- `clock`  in  1  single clock, rising-edge
- `reset`  in  1  asynchronous, active-high
- `if_req`  in  1  fetch read request, held until `if_ack`
- `if_addr`  in  ADDR_WIDTH  fetch address, stable while `if_req`
- `if_ack`  out  1  one-cycle completion pulse for fetch
- `if_rdata`  out  DATA_WIDTH  fetch read data, equals `ram_rdata` while `if_ack`, else 0
- `dm_req`  in  1  data request, held until `dm_ack`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  store data
- `dm_ack`  out  1  one-cycle completion pulse for data
- `dm_rdata`  out  DATA_WIDTH  load data, equals `ram_rdata` while `dm_ack` and the access is a load, else 0
- `ram_en`  out  1  RAM access strobe
- `ram_we`  out  1  RAM write enable, only with `ram_en`
- `ram_addr`  out  ADDR_WIDTH  RAM address
- `ram_wdata`  out  DATA_WIDTH  RAM write data
- `ram_rdata`  in  DATA_WIDTH  RAM read data, valid the cycle after the sampling edge
- `busy`  out  1  high whenever the state is not IDLE

## Operation
States and transitions:
- **IDLE**
  - Arbitrate combinationally.
  - If any request is present, register the grant (`grant_dm`), `ram_addr`, `ram_we`, `ram_wdata` and `ram_en`=1, then go to ACCESS.
  - If no request is present, stay in IDLE.
- **ACCESS**
  - `ram_en`=1 for exactly this cycle. The RAM samples at the edge that ends it.
  - Always go to RESP.
- **RESP**
  - `ram_en`=0 and `ram_we`=0.
  - The granted requester's ack is 1. Its rdata passes `ram_rdata` through for a load or fetch.
  - Always go to IDLE.

Arbitration rules:
- Data has priority over fetch, subject to the guard.
- Only word-wide accesses exist. There are no byte strobes.
- A fetch grant always drives `ram_we`=0. A data grant drives `ram_we`=`dm_we`, and `ram_wdata` is forced to 0 when `dm_we`=0.
- Stores also pass through RESP and are acked there. `dm_rdata` is 0 for a store.

Requester handshake:
- A requester drops `req` at the edge that ends its ack cycle.
- A `req` still high in the following IDLE cycle is a new request. This allows back-to-back accesses.

Starvation guard (guard builds only):
- `starve_cnt` is 4 bits.
- In IDLE with both requests present:
  - If `starve_cnt` == `STARVE_LIMIT`, fetch is granted and `starve_cnt` is cleared.
  - Otherwise data is granted and `starve_cnt` increments.
- On any fetch grant, or when `if_req`=0 during an IDLE that grants data, `starve_cnt` is cleared.
- `starve_cnt` saturates at `STARVE_LIMIT`.

Reset:
- `reset` high forces IDLE immediately, without waiting for a clock edge.
- All outputs are 0 and `starve_cnt` is 0.
- An in-flight access is abandoned with no ack. A store whose ACCESS cycle is cut by reset is not guaranteed to be written.

## Timing
- Reset values: `if_ack`, `dm_ack`, `ram_en`, `ram_we`, `busy` = 0. `ram_addr`, `ram_wdata`, `if_rdata`, `dm_rdata` = 0.
- Latency: a request seen in IDLE in cycle T gives `ram_en` in T+1 and the ack in T+2.
- Throughput: one access per 3 cycles. A requester holding `req` across its ack is served again with its ack at T+5.
- Simultaneous requests at T: data is acked at T+2 and fetch is acked at T+5.
- All `ram_*` outputs and the acks are registered. `if_rdata` and `dm_rdata` are the only combinational paths, gated by the ack.
- A request that arrives while `busy` is not observed until the next IDLE.

## Configuration
- Macro: `MEM_ARB_STARVE_GUARD_EN`.
- Defined: the starvation guard and the `STARVE_LIMIT` counter are compiled in as described above.
- Undefined: strict data priority applies, there is no counter, and fetch waits indefinitely while `dm_req` stays asserted. `STARVE_LIMIT` is ignored.

## Test plan
- Single fetch: RAM word 0x10 = 0xDEADBEEF, `if_req` with `if_addr`=0x10 at T -> `ram_en`=1, `ram_we`=0, `ram_addr`=0x10 at T+1; `if_ack`=1 with `if_rdata`=0xDEADBEEF at T+2; `busy` low at T+3.
- Store then load: `dm_we`=1, `dm_addr`=0x20, `dm_wdata`=0x12345678 -> `ram_we`=1 only in T+1, `dm_ack` at T+2 with `dm_rdata`=0. A following load of 0x20 -> `dm_rdata`=0x12345678 with its ack.
- Collision: `if_req` and `dm_req` both rise at T -> `dm_ack` at T+2, `if_ack` at T+5, never both acks in the same cycle.
- Starvation, guard defined, `STARVE_LIMIT`=4: `dm_req` held continuously and `if_req` held -> 4 `dm_ack` pulses, then `if_ack`, then data again. Guard undefined: no `if_ack` during 10 data accesses.
- Reset mid-access: `reset` pulsed during ACCESS -> `ram_en` and `busy` drop to 0 before the next edge and no ack is produced. After release, a fetch is served with 3-cycle latency.
- Back-to-back: `dm_req` held through two acks with addresses 0x0 then 0x4 -> acks at T+2 and T+5 with the correct data each.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous RAM port between the fetch and data stages.
// Defining MEM_ARB_STARVE_GUARD_EN compiles in the fetch starvation guard.
module mem_arbiter #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  if_req,
   input  logic [ADDR_WIDTH-1:0] if_addr,
   output logic                  if_ack,
   output logic [DATA_WIDTH-1:0] if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [ADDR_WIDTH-1:0] dm_addr,
   input  logic [DATA_WIDTH-1:0] dm_wdata,
   output logic                  dm_ack,
   output logic [DATA_WIDTH-1:0] dm_rdata,
   output logic                  ram_en,
   output logic                  ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   localparam logic [3:0] LP_STARVE_LIMIT = 4'(STARVE_LIMIT);

   state_t                r_state;
   logic                  r_grant_dm;
   logic                  r_grant_we;
   logic                  r_ram_en;
   logic                  r_ram_we;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [DATA_WIDTH-1:0] r_ram_wdata;
   logic                  r_if_ack;
   logic                  r_dm_ack;
   logic                  r_busy;

   logic                  w_any_req;
   logic                  w_pick_dm;

   assign w_any_req = if_req | dm_req;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic [3:0] r_starve_cnt;
   logic       w_starve_hit;

   // A pending fetch that has waited out the limit takes the next grant.
   assign w_starve_hit = if_req && (r_starve_cnt == LP_STARVE_LIMIT);
   assign w_pick_dm    = dm_req && !w_starve_hit;

   // Count consecutive data grants that overtook a pending fetch.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_starve_cnt <= 4'd0;
      end else if ((r_state == S_IDLE) && w_any_req) begin
         if (!w_pick_dm) begin
            r_starve_cnt <= 4'd0;
         end else if (!if_req) begin
            r_starve_cnt <= 4'd0;
         end else if (r_starve_cnt != LP_STARVE_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
         end else begin
            r_starve_cnt <= r_starve_cnt;
         end
      end else begin
         r_starve_cnt <= r_starve_cnt;
      end
   end
`else
   logic w_unused_limit;

   assign w_pick_dm      = dm_req;
   assign w_unused_limit = ^LP_STARVE_LIMIT;
`endif

   // Three-state access controller; every RAM strobe and ack is registered here.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_grant_dm  <= 1'b0;
         r_grant_we  <= 1'b0;
         r_ram_en    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= {ADDR_WIDTH{1'b0}};
         r_ram_wdata <= {DATA_WIDTH{1'b0}};
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any_req) begin
                  r_state    <= S_ACCESS;
                  r_ram_en   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_grant_dm <= w_pick_dm;
                  if (w_pick_dm) begin
                     r_grant_we  <= dm_we;
                     r_ram_we    <= dm_we;
                     r_ram_addr  <= dm_addr;
                     r_ram_wdata <= dm_we ? dm_wdata : {DATA_WIDTH{1'b0}};
                  end else begin
                     r_grant_we  <= 1'b0;
                     r_ram_we    <= 1'b0;
                     r_ram_addr  <= if_addr;
                     r_ram_wdata <= {DATA_WIDTH{1'b0}};
                  end
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_ACCESS: begin
               // The RAM samples at the edge that ends this state.
               r_state  <= S_RESP;
               r_ram_en <= 1'b0;
               r_ram_we <= 1'b0;
               r_if_ack <= ~r_grant_dm;
               r_dm_ack <= r_grant_dm;
            end
            S_RESP: begin
               r_state  <= S_IDLE;
               r_if_ack <= 1'b0;
               r_dm_ack <= 1'b0;
               r_busy   <= 1'b0;
            end
            default: begin
               r_state  <= S_IDLE;
               r_ram_en <= 1'b0;
               r_ram_we <= 1'b0;
               r_if_ack <= 1'b0;
               r_dm_ack <= 1'b0;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign if_ack    = r_if_ack;
   assign dm_ack    = r_dm_ack;
   assign ram_en    = r_ram_en;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign busy      = r_busy;

   // Read data is live only during the owning requester's ack; stores return zero.
   assign if_rdata = r_if_ack ? ram_rdata : {DATA_WIDTH{1'b0}};
   assign dm_rdata = (r_dm_ack && !r_grant_we) ? ram_rdata : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural synchronous RAM.
// Sequence expectations follow MEM_ARB_STARVE_GUARD_EN when it is defined.
module tb_mem_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'h0;
   logic        if_ack;
   logic [31:0] if_rdata;
   logic        dm_req = 1'b0;
   logic        dm_we = 1'b0;
   logic [31:0] dm_addr = 32'h0;
   logic [31:0] dm_wdata = 32'h0;
   logic        dm_ack;
   logic [31:0] dm_rdata;
   logic        ram_en;
   logic        ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;
   logic        busy;

   logic [31:0] mem [0:255];
   logic [31:0] exp_if_q[$];
   logic [31:0] exp_dm_q[$];
   int          n_pass = 0;
   int          n_total = 0;

   mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
      .clock(clock), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   always #5 clock = ~clock;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h10] <= 32'hDEADBEEF;
      mem[8'h00] <= 32'h0000_1111;
      mem[8'h04] <= 32'hA5A5_0004;
   end

   // Synchronous RAM: read data appears the cycle after the sampling edge.
   always @(posedge clock) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr[7:0]];
      end
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Wait for the next ack: 0 = fetch, 1 = data, -1 = none within the budget.
   task automatic wait_ack(output int kind);
      kind = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (if_ack || dm_ack) begin
            kind = dm_ack ? 1 : 0;
            break;
         end
      end
   endtask

   // Monitor: every ack pops its requester's queue; idle rdata must be zero.
   always @(negedge clock) begin
      if (!reset) begin
         if (if_ack || dm_ack) chk("both_acks", {63'd0, if_ack & dm_ack}, 64'd0);
         if (if_ack) begin
            if (exp_if_q.size() == 0) chk("if_ack_unexpected", 64'd1, 64'd0);
            else chk("if_rdata", {32'd0, if_rdata}, {32'd0, exp_if_q.pop_front()});
         end else begin
            chk("if_rdata_idle", {32'd0, if_rdata}, 64'd0);
         end
         if (dm_ack) begin
            if (exp_dm_q.size() == 0) chk("dm_ack_unexpected", 64'd1, 64'd0);
            else chk("dm_rdata", {32'd0, dm_rdata}, {32'd0, exp_dm_q.pop_front()});
         end else begin
            chk("dm_rdata_idle", {32'd0, dm_rdata}, 64'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int k;
      int n_acc;
      int f_idx;
      int last_d;

      // Reset state, during and just after reset.
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("reset_outs", {if_ack, dm_ack, ram_en, ram_we, busy, ram_addr, ram_wdata}, 64'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      chk("post_reset_outs", {if_ack, dm_ack, ram_en, ram_we, busy, ram_addr, ram_wdata}, 64'd0);

      // Single fetch.
      tick();
      if_req = 1'b1; if_addr = 32'h10;
      exp_if_q.push_back(32'hDEADBEEF);
      @(negedge clock);
      chk("fetch_T_busy", {63'd0, busy}, 64'd0);
      tick(); @(negedge clock);
      chk("fetch_T1_ram", {ram_en, ram_we, busy, ram_addr}, {3'b101, 32'h10});
      tick(); @(negedge clock);
      chk("fetch_T2_ack", {if_ack, dm_ack}, 2'b10);
      tick(); if_req = 1'b0;
      @(negedge clock);
      chk("fetch_T3_idle", {busy, ram_en}, 2'b00);

      // Store then back-to-back load of the same word.
      tick();
      dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'h12345678;
      exp_dm_q.push_back(32'h0);
      @(negedge clock);
      chk("store_T_we", {63'd0, ram_we}, 64'd0);
      tick(); @(negedge clock);
      chk("store_T1_ram", {ram_en, ram_we, ram_wdata}, {2'b11, 32'h12345678});
      tick(); @(negedge clock);
      chk("store_T2_ack", {dm_ack, ram_we, ram_en}, 3'b100);
      tick();
      dm_we = 1'b0; dm_wdata = 32'h0;
      exp_dm_q.push_back(32'h12345678);
      @(negedge clock);
      chk("store_mem", {32'd0, mem[8'h20]}, {32'd0, 32'h12345678});
      tick(); @(negedge clock);
      chk("load_T1_ram", {ram_en, ram_we, ram_wdata}, {2'b10, 32'h0});
      tick(); @(negedge clock);
      chk("load_T2_ack", {63'd0, dm_ack}, 64'd1);
      tick(); dm_req = 1'b0;

      // Collision: data first at T+2, fetch at T+5.
      tick();
      if_req = 1'b1; if_addr = 32'h10; exp_if_q.push_back(32'hDEADBEEF);
      dm_req = 1'b1; dm_addr = 32'h20; exp_dm_q.push_back(32'h12345678);
      tick(); tick(); @(negedge clock);
      chk("coll_T2_acks", {if_ack, dm_ack}, 2'b01);
      tick(); dm_req = 1'b0;
      tick(); tick(); @(negedge clock);
      chk("coll_T5_acks", {if_ack, dm_ack}, 2'b10);
      tick(); if_req = 1'b0;

      // Starvation: both requests held.
`ifdef MEM_ARB_STARVE_GUARD_EN
      n_acc = 6; f_idx = 4; last_d = 5;
`else
      n_acc = 11; f_idx = 10; last_d = 9;
`endif
      for (int i = 0; i < n_acc - 1; i++) exp_dm_q.push_back(32'hA5A5_0004);
      exp_if_q.push_back(32'hDEADBEEF);
      tick();
      if_req = 1'b1; if_addr = 32'h10;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h4;
      for (int i = 0; i < n_acc; i++) begin
         wait_ack(k);
         chk($sformatf("starve_seq%0d", i), 64'(k), (i == f_idx) ? 64'd0 : 64'd1);
         if (i == f_idx || i == last_d) begin
            @(posedge clock); #1;
            if (i == f_idx) if_req = 1'b0;
            if (i == last_d) dm_req = 1'b0;
         end
      end
      tick(); tick();

      // Reset during ACCESS: strobes drop at once, no ack follows.
      if_req = 1'b1; if_addr = 32'h10;
      tick();
      chk("rst_pre_access", {ram_en, busy}, 2'b11);
      reset = 1'b1;
      #1;
      chk("rst_async_drop", {ram_en, busy, if_ack}, 3'b000);
      if_req = 1'b0;
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_no_ack", {if_ack, dm_ack, busy}, 3'b000);
      tick();
      if_req = 1'b1; exp_if_q.push_back(32'hDEADBEEF);
      tick(); @(negedge clock);
      chk("rst_fetch_T1", {ram_en, ram_addr}, {1'b1, 32'h10});
      tick(); @(negedge clock);
      chk("rst_fetch_T2", {63'd0, if_ack}, 64'd1);
      tick(); if_req = 1'b0;

      // Back-to-back data loads of 0x0 then 0x4.
      tick();
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0;
      exp_dm_q.push_back(32'h0000_1111);
      exp_dm_q.push_back(32'hA5A5_0004);
      tick(); tick(); @(negedge clock);
      chk("b2b_T2_ack", {63'd0, dm_ack}, 64'd1);
      tick(); dm_addr = 32'h4;
      @(negedge clock);
      chk("b2b_T3_gap", {dm_ack, busy}, 2'b00);
      tick(); tick(); @(negedge clock);
      chk("b2b_T5_ack", {63'd0, dm_ack}, 64'd1);
      tick(); dm_req = 1'b0;
      tick(); tick();

      chk("if_queue_empty", 64'(exp_if_q.size()), 64'd0);
      chk("dm_queue_empty", 64'(exp_dm_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
